// File: rtl/frv_mem_responder_pkg.sv
// Shared types and constants for the frv memory responder.
// Holds the FSM encoding, LFSR taps and error-counter ceiling.
package frv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } mem_state_t;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

    function automatic logic [15:0] lfsr_step(logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/frv_mem_responder_if.sv
// req/gnt memory bus between a core port and its responder.
// The master drives the request fields; the slave answers.
interface frv_mem_if;
    import frv_mem_pkg::*;

    logic        mem_req;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_error;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr,
        input  mem_gnt, mem_error, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr,
        output mem_gnt, mem_error, mem_rdata
    );

endinterface

// File: rtl/frv_mem_responder_ram.sv
// Word-wide synchronous RAM with byte enables and a registered
// read port, shaped so FPGA tools map it onto block RAM.
module frv_mem_responder_ram
    import frv_mem_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/frv_mem_responder.sv
// Memory-side responder: wait-state FSM, window decode, response
// registers and error bookkeeping around a byte-writable RAM.
module frv_mem_responder
    import frv_mem_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
    parameter int unsigned MEM_SIZE    = 65536,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter bit          RAND_STALL  = 1'b0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    frv_mem_if.slave         mem,
    output logic [15:0]      err_count,
    output logic             proto_err
);

    localparam int          DEPTH  = int'(MEM_SIZE / 4);
    localparam int          AW     = (MEM_SIZE > 4) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SIZE33 = 33'(MEM_SIZE);

    mem_state_t  state_q;
    logic [4:0]  wcnt_q;
    logic [4:0]  wcnt_init;
    logic [15:0] lfsr_q;
    logic        gnt_q;
    logic        err_q;
    logic        rd_sel_q;
    logic [15:0] err_cnt_q;
    logic        proto_q;

    logic [31:0] offset;
    logic        hit;
    logic        grant;
    logic [3:0]  ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;

    // Offset is only meaningful when addr >= base, so no wrap;
    // the 33-bit compare keeps a window ending at 2^32 exact.
    assign offset = mem.mem_addr - MEM_BASE;
    assign hit    = (mem.mem_addr >= MEM_BASE) &&
                    ({1'b0, offset} < SIZE33);

    assign wcnt_init = 5'(WAIT_CYCLES) +
                       (RAND_STALL ? {3'b000, lfsr_q[1:0]} : 5'd0);

    assign grant  = (state_q == GRANT);
    assign ram_we = (grant && hit && mem.mem_wen) ? mem.mem_strb : 4'h0;
    assign ram_re = grant && hit && !mem.mem_wen;

    frv_mem_responder_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (g_clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (offset[AW+1:2]),
        .wdata (mem.mem_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q   <= IDLE;
            wcnt_q    <= 5'd0;
            lfsr_q    <= LFSR_SEED;
            gnt_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_sel_q  <= 1'b0;
            err_cnt_q <= 16'h0000;
            proto_q   <= 1'b0;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
            gnt_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (mem.mem_req) begin
                        wcnt_q <= wcnt_init;
                        if (wcnt_init == 5'd0) begin
                            state_q <= GRANT;
                            gnt_q   <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!mem.mem_req) begin
                        proto_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (wcnt_q == 5'd1) begin
                        state_q <= GRANT;
                        gnt_q   <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q - 5'd1;
                    end
                end
                GRANT: begin
                    state_q  <= IDLE;
                    err_q    <= !hit;
                    rd_sel_q <= hit && !mem.mem_wen;
                    if (!hit && err_cnt_q != ERR_COUNT_MAX)
                        err_cnt_q <= err_cnt_q + 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM output only moves on a read grant, so it holds with the flag
    assign mem.mem_gnt   = gnt_q;
    assign mem.mem_error = err_q;
    assign mem.mem_rdata = rd_sel_q ? ram_rdata : 32'h0;
    assign err_count     = err_cnt_q;
    assign proto_err     = proto_q;

endmodule

// File: tb/tb_frv_mem_responder.sv
// Directed bench: three responders (no wait, 3 waits, random stall)
// driven side by side on one clock and reset.
module tb_frv_mem_responder;
    import frv_mem_pkg::*;

    logic clk;
    logic rst_n;

    logic        req   [3];
    logic        wen   [3];
    logic [3:0]  strb  [3];
    logic [31:0] wdata [3];
    logic [31:0] addr  [3];
    logic        gnt   [3];
    logic        err   [3];
    logic [31:0] rdata [3];
    logic [15:0] ecnt  [3];
    logic        perr  [3];
    logic        gnt_prev [3];

    int checks   = 0;
    int failures = 0;
    int dbl_gnt  = 0;

    frv_mem_if if0 ();
    frv_mem_if if3 ();
    frv_mem_if ifr ();

    assign if0.mem_req = req[0];   assign if3.mem_req = req[1];
    assign ifr.mem_req = req[2];
    assign if0.mem_wen = wen[0];   assign if3.mem_wen = wen[1];
    assign ifr.mem_wen = wen[2];
    assign if0.mem_strb = strb[0]; assign if3.mem_strb = strb[1];
    assign ifr.mem_strb = strb[2];
    assign if0.mem_wdata = wdata[0]; assign if3.mem_wdata = wdata[1];
    assign ifr.mem_wdata = wdata[2];
    assign if0.mem_addr = addr[0]; assign if3.mem_addr = addr[1];
    assign ifr.mem_addr = addr[2];
    assign gnt[0] = if0.mem_gnt;   assign gnt[1] = if3.mem_gnt;
    assign gnt[2] = ifr.mem_gnt;
    assign err[0] = if0.mem_error; assign err[1] = if3.mem_error;
    assign err[2] = ifr.mem_error;
    assign rdata[0] = if0.mem_rdata; assign rdata[1] = if3.mem_rdata;
    assign rdata[2] = ifr.mem_rdata;

    frv_mem_responder #(.WAIT_CYCLES(0), .RAND_STALL(1'b0)) u_d0 (
        .g_clk(clk), .g_resetn(rst_n), .mem(if0),
        .err_count(ecnt[0]), .proto_err(perr[0])
    );
    frv_mem_responder #(.WAIT_CYCLES(3), .RAND_STALL(1'b0)) u_d3 (
        .g_clk(clk), .g_resetn(rst_n), .mem(if3),
        .err_count(ecnt[1]), .proto_err(perr[1])
    );
    frv_mem_responder #(.WAIT_CYCLES(0), .RAND_STALL(1'b1)) u_dr (
        .g_clk(clk), .g_resetn(rst_n), .mem(ifr),
        .err_count(ecnt[2]), .proto_err(perr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && gnt[k] && gnt_prev[k]) dbl_gnt++;
            gnt_prev[k] = gnt[k];
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives one transaction from cycle T; returns cycles to grant
    // (0 on timeout) and the response seen in the following cycle.
    task automatic xact(input int d, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic er);
        req[d] = 1'b1; wen[d] = w; strb[d] = s;
        addr[d] = a;   wdata[d] = wd;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (gnt[d]) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            chk("grant_timeout", 32'd0, 32'd1);
            req[d] = 1'b0;
            rd = 32'h0; er = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
        rd = rdata[d];
        er = err[d];
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [31:0] model [64];
    int          bad_lat, bad_data, bad_err, n_gnt;

    initial begin
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; wen[k] = 1'b0; strb[k] = 4'h0;
            wdata[k] = 32'h0; addr[k] = 32'h0; gnt_prev[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt[0]), 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_ecnt", 32'(ecnt[0]), 32'd0);
        chk("rst_perr", 32'(perr[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // zero-wait write then read back
        xact(0, 1'b1, 4'hF, 32'h8000_0010, 32'hDEADBEEF, lat, rd, er);
        chk("w0_lat", 32'(lat), 32'd1);
        chk("w0_err", 32'(er), 32'd0);
        chk("w0_rdata", rd, 32'h0);
        xact(0, 1'b0, 4'h0, 32'h8000_0010, 32'h0, lat, rd, er);
        chk("r0_lat", 32'(lat), 32'd1);
        chk("r0_rdata", rd, 32'hDEADBEEF);
        chk("r0_err", 32'(er), 32'd0);

        // single-byte strobe merge
        xact(0, 1'b1, 4'hF, 32'h8000_0020, 32'h1122_3344, lat, rd, er);
        xact(0, 1'b1, 4'h1, 32'h8000_0020, 32'h0000_00AA, lat, rd, er);
        xact(0, 1'b0, 4'h0, 32'h8000_0020, 32'h0, lat, rd, er);
        chk("strb_merge", rd, 32'h1122_33AA);

        // below and just past the window
        xact(0, 1'b1, 4'hF, 32'h8000_0000, 32'h0BAD_F00D, lat, rd, er);
        xact(0, 1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0, lat, rd, er);
        chk("miss_lo_err", 32'(er), 32'd1);
        chk("miss_lo_rdata", rd, 32'h0);
        xact(0, 1'b0, 4'h0, 32'h8001_0000, 32'h0, lat, rd, er);
        chk("miss_hi_err", 32'(er), 32'd1);
        chk("miss_hi_rdata", rd, 32'h0);
        chk("miss_ecnt", 32'(ecnt[0]), 32'd2);
        xact(0, 1'b1, 4'hF, 32'h8001_0000, 32'h5555_5555, lat, rd, er);
        chk("miss_w_err", 32'(er), 32'd1);
        xact(0, 1'b0, 4'h0, 32'h8000_0000, 32'h0, lat, rd, er);
        chk("miss_w_ram", rd, 32'h0BAD_F00D);
        chk("last_word_err", 32'(er), 32'd0);
        xact(0, 1'b0, 4'h0, 32'h8000_FFFC, 32'h0, lat, rd, er);
        chk("top_word_err", 32'(er), 32'd0);

        // zero-strobe write is a no-op
        xact(0, 1'b1, 4'h0, 32'h8000_0010, 32'hFFFF_FFFF, lat, rd, er);
        chk("strb0_err", 32'(er), 32'd0);
        xact(0, 1'b0, 4'h0, 32'h8000_0010, 32'h0, lat, rd, er);
        chk("strb0_ram", rd, 32'hDEADBEEF);

        // three wait states
        xact(1, 1'b1, 4'hF, 32'h8000_0040, 32'hCAFE_BABE, lat, rd, er);
        chk("w3_lat", 32'(lat), 32'd4);
        xact(1, 1'b0, 4'h0, 32'h8000_0040, 32'h0, lat, rd, er);
        chk("r3_lat", 32'(lat), 32'd4);
        chk("r3_rdata", rd, 32'hCAFE_BABE);

        // request dropped while waiting
        req[1] = 1'b1; wen[1] = 1'b1; strb[1] = 4'hF;
        addr[1] = 32'h8000_0040; wdata[1] = 32'h0;
        n_gnt = 0;
        @(posedge clk); #1;
        if (gnt[1]) n_gnt++;
        @(posedge clk); #1;
        if (gnt[1]) n_gnt++;
        req[1] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (gnt[1]) n_gnt++;
        end
        chk("drop_no_gnt", 32'(n_gnt), 32'd0);
        chk("drop_perr", 32'(perr[1]), 32'd1);
        xact(1, 1'b0, 4'h0, 32'h8000_0040, 32'h0, lat, rd, er);
        chk("drop_ram", rd, 32'hCAFE_BABE);
        chk("perr_sticky", 32'(perr[1]), 32'd1);

        // random stall against a scoreboard
        for (int i = 0; i < 64; i++) begin
            model[i] = $urandom;
            xact(2, 1'b1, 4'hF, 32'h8000_0000 + 32'(i * 4), model[i],
                 lat, rd, er);
        end
        bad_lat = 0; bad_data = 0; bad_err = 0;
        for (int n = 0; n < 1000; n++) begin
            int          idx;
            logic        w;
            logic [3:0]  s;
            logic [31:0] wd;
            idx = $urandom_range(0, 63);
            w   = 1'($urandom_range(0, 1));
            s   = 4'($urandom_range(0, 15));
            wd  = $urandom;
            xact(2, w, s, 32'h8000_0000 + 32'(idx * 4), wd, lat, rd, er);
            if (lat < 1 || lat > 4) bad_lat++;
            if (er) bad_err++;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
                if (rd !== 32'h0) bad_data++;
            end else if (rd !== model[idx]) begin
                bad_data++;
            end
        end
        chk("rand_lat_range", 32'(bad_lat), 32'd0);
        chk("rand_data", 32'(bad_data), 32'd0);
        chk("rand_err", 32'(bad_err), 32'd0);
        chk("gnt_back_to_back", 32'(dbl_gnt), 32'd0);

        // error counter saturation
        @(negedge clk);
        force u_d0.err_cnt_q = 16'hFFFE;
        @(negedge clk);
        release u_d0.err_cnt_q;
        @(posedge clk); #1;
        chk("sat_preset", 32'(ecnt[0]), 32'h0000_FFFE);
        xact(0, 1'b0, 4'h0, 32'h0000_0000, 32'h0, lat, rd, er);
        chk("sat_one", 32'(ecnt[0]), 32'h0000_FFFF);
        xact(0, 1'b0, 4'h0, 32'h0000_0000, 32'h0, lat, rd, er);
        xact(0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, lat, rd, er);
        chk("sat_stick", 32'(ecnt[0]), 32'h0000_FFFF);

        // asynchronous reset in the middle of a wait
        req[1] = 1'b1; wen[1] = 1'b1; strb[1] = 4'hF;
        addr[1] = 32'h8000_0040; wdata[1] = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ecnt", 32'(ecnt[0]), 32'd0);
        chk("arst_err", 32'(err[0]), 32'd0);
        chk("arst_perr", 32'(perr[1]), 32'd0);
        chk("arst_rdata", rdata[1], 32'h0);
        chk("arst_gnt", 32'(gnt[1]), 32'd0);
        req[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        xact(1, 1'b0, 4'h0, 32'h8000_0040, 32'h0, lat, rd, er);
        chk("arst_no_write", rd, 32'hCAFE_BABE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
